// File: rtl/align_shift_pipe.sv
// Pipelined right shifter for FP-add mantissa alignment: one shift level per register, produces guard/round/sticky.
// Latency clog2(WIDTH) cycles; a full output stalls every level together, so in_ready = ~(out_valid & ~out_ready).
module align_shift_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 8,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_num,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_arith,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_num,
    output logic               out_guard,
    output logic               out_round,
    output logic               out_sticky,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int L = $clog2(WIDTH);
    localparam int D = WIDTH + 2;
    localparam logic [SHAMT_W-1:0] SH_W  = SHAMT_W'(WIDTH);
    localparam logic [SHAMT_W-1:0] SH_W1 = SHAMT_W'(WIDTH + 1);
    localparam logic [SHAMT_W-1:0] SH_W3 = SHAMT_W'(WIDTH + 3);

    // Data word is {fraction, guard, round}; returns {shifted word, updated sticky}.
    function automatic logic [D:0] shift_step(
        input logic [D-1:0] dat,
        input logic         stk,
        input logic         fill,
        input logic         en,
        input int           amt
    );
        logic [D-1:0] fill_mask;
        logic [D-1:0] lost_mask;
        fill_mask = fill ? ~({D{1'b1}} >> amt) : '0;
        lost_mask = ~({D{1'b1}} << amt);
        if (en) begin
            return {(dat >> amt) | fill_mask, stk | (|(dat & lost_mask))};
        end
        return {dat, stk};
    endfunction

    logic             vld_q  [L];
    logic [D-1:0]     dat_q  [L];
    logic             stk_q  [L];
    logic [TAG_W-1:0] tag_q  [L];
    // The last level needs neither the fill bit nor any shift bits.
    logic             fill_q [L-1];
    logic [L-1:0]     sh_q   [L-1];

    logic [D-1:0]     dat_d  [L];
    logic             stk_d  [L];
    logic             fill0;
    logic             sat0;
    logic [D:0]       step;
    logic             stall;

    assign stall    = vld_q[L-1] & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        for (int k = 0; k < L; k++) begin
            dat_d[k] = '0;
            stk_d[k] = 1'b0;
        end
        fill0 = in_arith & in_num[WIDTH-1];
        sat0  = |in_shamt[SHAMT_W-1:L];
        step  = shift_step({in_num, 2'b00}, 1'b0, fill0, in_shamt[0], 1);
        dat_d[0] = step[D:1];
        stk_d[0] = step[0];
        // Shifts of WIDTH and WIDTH+1 still expose original bits in guard/round.
        if (sat0) begin
            if (in_shamt == SH_W) begin
                dat_d[0] = {{WIDTH{fill0}}, in_num[WIDTH-1:WIDTH-2]};
                stk_d[0] = |in_num[WIDTH-3:0];
            end else if (in_shamt == SH_W1) begin
                dat_d[0] = {{WIDTH{fill0}}, fill0, in_num[WIDTH-1]};
                stk_d[0] = |in_num[WIDTH-2:0];
            end else begin
                dat_d[0] = {D{fill0}};
                stk_d[0] = (|in_num) | (fill0 & (in_shamt >= SH_W3));
            end
        end
        for (int k = 1; k < L; k++) begin
            step     = shift_step(dat_q[k-1], stk_q[k-1], fill_q[k-1], sh_q[k-1][k], 1 << k);
            dat_d[k] = step[D:1];
            stk_d[k] = step[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                vld_q[k] <= 1'b0;
                dat_q[k] <= '0;
                stk_q[k] <= 1'b0;
                tag_q[k] <= '0;
            end
            for (int k = 0; k < L - 1; k++) begin
                fill_q[k] <= 1'b0;
                sh_q[k]   <= '0;
            end
        end else if (!stall) begin
            vld_q[0]  <= in_valid;
            dat_q[0]  <= dat_d[0];
            stk_q[0]  <= stk_d[0];
            tag_q[0]  <= in_tag;
            fill_q[0] <= fill0;
            sh_q[0]   <= sat0 ? '0 : in_shamt[L-1:0];
            for (int k = 1; k < L; k++) begin
                vld_q[k] <= vld_q[k-1];
                dat_q[k] <= dat_d[k];
                stk_q[k] <= stk_d[k];
                tag_q[k] <= tag_q[k-1];
            end
            for (int k = 1; k < L - 1; k++) begin
                fill_q[k] <= fill_q[k-1];
                sh_q[k]   <= sh_q[k-1];
            end
        end
    end

    assign out_valid  = vld_q[L-1];
    assign out_num    = dat_q[L-1][D-1:2];
    assign out_guard  = dat_q[L-1][1];
    assign out_round  = dat_q[L-1][0];
    assign out_sticky = stk_q[L-1];
    assign out_tag    = tag_q[L-1];
endmodule

// File: tb/tb_align_shift_pipe.sv
// Directed and random bench for align_shift_pipe with a conceptual-model scoreboard.
module tb_align_shift_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_num;
    logic [7:0]  in_shamt;
    logic        in_arith;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_num;
    logic        out_guard;
    logic        out_round;
    logic        out_sticky;
    logic [3:0]  out_tag;

    int n_chk = 0;
    int n_err = 0;
    logic [38:0] sb[$];
    logic [38:0] snap;
    bit          prev_stall = 0;
    bit          rnd_done;

    align_shift_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
        .in_shamt(in_shamt), .in_arith(in_arith), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num),
        .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Bit j of E: two zero bits under the LSB, fill above the MSB.
    function automatic logic ebit(input logic [31:0] n, input logic f, input int j);
        if (j < 2) return 1'b0;
        if (j < 34) return n[j-2];
        return f;
    endfunction

    function automatic logic [38:0] model(input logic [31:0] n, input logic [7:0] s,
                                          input logic a, input logic [3:0] t);
        logic f;
        logic [31:0] r;
        logic st;
        f  = a & n[31];
        st = 1'b0;
        for (int i = 0; i < 32; i++) r[i] = ebit(n, f, i + 2 + int'(s));
        for (int j = 0; j < int'(s) - 2; j++) st |= (j < 32) ? n[j] : f;
        return {r, ebit(n, f, 1 + int'(s)), ebit(n, f, int'(s)), st, t};
    endfunction

    wire [38:0] obs = {out_num, out_guard, out_round, out_sticky, out_tag};

    always @(negedge clk) begin
        logic [38:0] e;
        if (rst) begin
            sb.delete();
            prev_stall = 0;
        end else begin
            n_chk++;
            assert (in_ready === !(out_valid && !out_ready)) else begin
                n_err++; $error("FAIL in_ready: observed %b expected %b", in_ready, !(out_valid && !out_ready));
            end
            if (prev_stall) begin
                n_chk++;
                assert (obs === snap) else begin
                    n_err++; $error("FAIL stall_stable: observed %h expected %h", obs, snap);
                end
            end
            if (out_valid && out_ready) begin
                n_chk++;
                assert (sb.size() != 0) else begin
                    n_err++; $error("FAIL unexpected_output: observed %h expected none", obs);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_chk++;
                    assert (obs === e) else begin
                        n_err++; $error("FAIL result: observed %h expected %h", obs, e);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_num, in_shamt, in_arith, in_tag));
            prev_stall = out_valid && !out_ready;
            snap = obs;
        end
    end

    task automatic send(input logic [31:0] n, input logic [7:0] s, input logic a, input logic [3:0] t);
        bit acc;
        int cnt;
        in_num = n; in_shamt = s; in_arith = a; in_tag = t; in_valid = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cnt++;
        end while (!acc && cnt < 1000);
        in_valid = 1'b0;
        if (!acc) begin
            n_chk++;
            assert (acc) else begin
                n_err++; $error("FAIL accept_timeout: observed in_ready %b expected 1", in_ready);
            end
        end
    endtask

    task automatic directed(input string name, input logic [31:0] n, input logic [7:0] s,
                            input logic a, input logic [3:0] t, input logic [31:0] xn,
                            input logic xg, input logic xr, input logic xs);
        int lat;
        in_num = n; in_shamt = s; in_arith = a; in_tag = t; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_chk++;
        assert (lat === 5) else begin
            n_err++; $error("FAIL %s latency: observed %0d expected 5", name, lat);
        end
        n_chk++;
        assert (obs === {xn, xg, xr, xs, t}) else begin
            n_err++; $error("FAIL %s value: observed %h expected %h", name, obs, {xn, xg, xr, xs, t});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int cnt = 0;
        while (sb.size() != 0 && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        n_chk++;
        assert (sb.size() == 0) else begin
            n_err++; $error("FAIL drain: observed %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_num = '0; in_shamt = '0; in_arith = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_chk++;
        assert (out_valid === 1'b0 && in_ready === 1'b1 && obs === 39'd0) else begin
            n_err++; $error("FAIL reset_state: observed v=%b r=%b o=%h expected v=0 r=1 o=0", out_valid, in_ready, obs);
        end

        directed("basic",      32'h0080_0001, 8'd3,   1'b0, 4'h5, 32'h0010_0000, 1'b0, 1'b0, 1'b1);
        directed("zero",       32'hDEAD_BEEF, 8'd0,   1'b1, 4'h6, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        directed("shamt31",    32'hC000_0000, 8'd31,  1'b0, 4'h7, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        directed("sat_log",    32'h8000_0000, 8'd200, 1'b0, 4'h8, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        directed("sat_arith",  32'h8000_0000, 8'd200, 1'b1, 4'h9, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        directed("shamt32",    32'hA000_0005, 8'd32,  1'b0, 4'hA, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed("shamt33",    32'h8000_0000, 8'd33,  1'b1, 4'hB, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        directed("arith4",     32'hF000_0010, 8'd4,   1'b1, 4'hC, 32'hFF00_0001, 1'b0, 1'b0, 1'b0);

        // Backpressure: 8 back-to-back with a 3-cycle out_ready drop mid-stream.
        fork
            for (int i = 0; i < 8; i++) send($urandom, 8'($urandom_range(0, 40)), 1'($urandom), 4'(i));
            begin
                repeat (7) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with 4 in flight while an input is offered.
        for (int i = 0; i < 4; i++) send($urandom, 8'($urandom_range(0, 31)), 1'b0, 4'(i));
        rst = 1'b1; in_valid = 1'b1; in_num = 32'h1234_5678; in_shamt = 8'd1; in_tag = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        n_chk++;
        assert (out_valid === 1'b0 && in_ready === 1'b1) else begin
            n_err++; $error("FAIL mid_reset: observed v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        end
        repeat (10) @(posedge clk);
        #1;
        directed("post_reset", 32'h0000_0100, 8'd8, 1'b0, 4'h3, 32'h0000_0001, 1'b0, 1'b0, 1'b0);

        // Random traffic with random downstream readiness.
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send($urandom, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40)),
                         1'($urandom), 4'($urandom));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/align_shift_pipe.md
# align_shift_pipe

Pipelined, parametrised right shifter for mantissa alignment in the floating-point adder. It shifts the smaller operand's fraction right by the exponent difference and produces the guard, round and sticky bits that the rounding stage needs. It supports logical or arithmetic (sign-fill) shifting per transaction and carries a sideband tag. Valid/ready handshakes on both sides let it sit between the exponent-compare stage and the significand adder.

## Interface
- WIDTH, 32, data width in bits; power of two, 4..64
- SHAMT_W, 8, shift-amount width in bits; must be ≥ clog2(WIDTH)+1
- TAG_W, 4, sideband tag width in bits; carried unchanged through the pipeline
- Derived: L = clog2(WIDTH), the pipeline depth in cycles
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept an input this cycle
- in_num  in  WIDTH  value to shift
- in_shamt  in  SHAMT_W  unsigned shift amount
- in_arith  in  1  1 = arithmetic shift (fill with in_num MSB), 0 = logical shift (fill with 0)
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  output transaction valid
- out_ready  in  1  downstream accepts the output
- out_num  out  WIDTH  shifted result
- out_guard  out  1  first bit shifted out
- out_round  out  1  second bit shifted out
- out_sticky  out  1  OR of all bits shifted out below the round bit
- out_tag  out  TAG_W  tag of the transaction

## Operation
- Conceptual model: E is in_num extended infinitely left with the fill bit and with two zero bits appended below the LSB.
- out_num is bits [WIDTH+1 : 2] of (E >> in_shamt).
- out_guard is bit 1 and out_round is bit 0 of (E >> in_shamt).
- out_sticky is the OR of every original bit at positions below in_shamt-2. Bits beyond the MSB count as fill.
- in_shamt ≥ WIDTH: out_num is all fill bits; guard, round and sticky follow the model exactly. No wrap-around and no modulo on the shift amount.
- in_shamt = 0: out_num = in_num, and guard = round = sticky = 0.
- Structure: L registered levels. Level k conditionally shifts by 2^k and ORs all lost bits below round into a running sticky.
- Saturation is decided in level 0 from the upper bits in_shamt[SHAMT_W-1:L]. If any of those bits is set, the whole shift result is replaced by the saturated value.
- Each level register holds: valid, data (WIDTH+2 bits), sticky, arith fill bit, remaining shamt bits, and tag.
- Flow control uses a global stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - When stall is 1, every level holds its contents.
  - When stall is 0, every level advances and level 0 loads (in_valid, in_*). Bubbles propagate as valid = 0.
- An input is accepted when in_valid & in_ready. An output is transferred when out_valid & out_ready.
- Transaction order is preserved. There is no loss and no duplication.

## Timing
- Latency is exactly L cycles from acceptance to out_valid when unstalled (5 for WIDTH = 32). Each stall cycle adds one cycle.
- Throughput is one transaction per cycle with out_ready held high.
- in_ready is combinational from out_valid and out_ready. No other input-to-output combinational path exists.
- While stalled, out_num, out_guard, out_round, out_sticky and out_tag are stable.
- Reset, including mid-operation: on the first edge with rst = 1, all level valids and out_valid clear to 0, and all data, sticky and tag registers clear to 0.
  - in_ready is 1 from the edge after reset.
  - Transactions in flight are discarded.
  - Inputs presented while rst = 1 are not accepted.
- Simultaneous output transfer and input acceptance in the same cycle is legal and required.

## Test plan
- Basic shift: WIDTH = 32, num = 0x0080_0001, shamt = 3, logical -> out_num = 0x0010_0000, G = 0, R = 0, S = 1, out_valid exactly 5 cycles after acceptance, tag unchanged.
- Zero and boundary shifts:
  - shamt = 0, num = 0xDEAD_BEEF -> out_num = 0xDEAD_BEEF, G = R = S = 0.
  - shamt = 31, num = 0xC000_0000, logical -> out_num = 0x0000_0001, G = 1, R = 0, S = 0.
- Saturation:
  - shamt = 200, num = 0x8000_0000, logical -> out_num = 0, G = 0, R = 0, S = 1.
  - Same with arith = 1 -> out_num = 0xFFFF_FFFF, G = 1, R = 1, S = 1.
- Backpressure: stream 8 transactions back-to-back, drop out_ready for 3 cycles mid-stream -> in_ready is low exactly while out_valid & ~out_ready, outputs stay stable, all 8 results arrive in order against a reference model.
- Reset mid-stream: assert rst for 1 cycle with 4 transactions in flight -> out_valid = 0 the next cycle, no stale result emerges afterwards, the first post-reset transaction has latency 5.
- Randomised: 10k random num/shamt/arith/tag values with random out_ready -> every output matches the conceptual-model scoreboard.
